fpdiv_sequencer: RTL and testbench

FPDIV_SEQUENCER -- requirements
Module: fpdiv_sequencer

---
 rtl/fpdiv_sequencer.sv | 153 +++++++++++++++
 tb/tb_fpdiv_sequencer.sv | 260 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/fpdiv_sequencer.sv
// Sequences one IEEE-754 single divide: classifies specials in IDLE, holds operands on a settling divider for SETTLE_CYCLES, then holds the result.
// Latency: 1 cycle for special cases, SETTLE_CYCLES for normal ones; one transaction in flight, result held until OUT_READY.
module fpdiv_sequencer #(
  parameter int unsigned SETTLE_CYCLES = 25
) (
  input  logic        CLOCK,
  input  logic        RESET,
  input  logic        IN_VALID,
  output logic        IN_READY,
  input  logic [31:0] InputA,
  input  logic [31:0] InputB,
  output logic [31:0] DIV_A,
  output logic [31:0] DIV_B,
  input  logic [31:0] DIV_Q,
  output logic        OUT_VALID,
  input  logic        OUT_READY,
  output logic [31:0] AbyB,
  output logic        DONE,
  output logic [1:0]  EXCEPTION
);

  localparam logic [7:0]  CNT_INIT = 8'(SETTLE_CYCLES - 1);
  localparam logic [31:0] QNAN     = 32'h7FC0_0000;

  typedef enum logic [1:0] {IDLE, BUSY, HOLD} state_t;

  state_t      state_q, state_d;
  logic [7:0]  cnt_q, cnt_d;
  logic [31:0] div_a_q, div_a_d;
  logic [31:0] div_b_q, div_b_d;
  logic [31:0] abyb_q, abyb_d;
  logic [1:0]  exc_q, exc_d;

  logic [31:0] a_fl, b_fl, q_fl, spec_res;
  logic [1:0]  spec_exc, q_exc;
  logic        sign, is_special;
  logic        a_nan, a_inf, a_zero, b_nan, b_inf, b_zero;

  // Subnormals are flushed to signed zero before any classification.
  assign a_fl = (InputA[30:23] == 8'd0) ? {InputA[31], 31'd0} : InputA;
  assign b_fl = (InputB[30:23] == 8'd0) ? {InputB[31], 31'd0} : InputB;
  assign sign = InputA[31] ^ InputB[31];

  assign a_nan  = (&a_fl[30:23]) & (|a_fl[22:0]);
  assign a_inf  = (&a_fl[30:23]) & ~(|a_fl[22:0]);
  assign a_zero = ~(|a_fl[30:0]);
  assign b_nan  = (&b_fl[30:23]) & (|b_fl[22:0]);
  assign b_inf  = (&b_fl[30:23]) & ~(|b_fl[22:0]);
  assign b_zero = ~(|b_fl[30:0]);

  always_comb begin
    spec_res   = 32'd0;
    spec_exc   = 2'b00;
    is_special = 1'b1;
    if (a_nan | b_nan | (a_inf & b_inf) | (a_zero & b_zero)) begin
      spec_res = QNAN;
      spec_exc = 2'b10;
    end else if (a_inf) begin
      spec_res = {sign, 8'hFF, 23'd0};
      spec_exc = 2'b11;
    end else if (b_inf) begin
      spec_res = {sign, 31'd0};
      spec_exc = 2'b11;
    end else if (b_zero) begin
      spec_res = {sign, 8'hFF, 23'd0};
      spec_exc = 2'b01;
    end else if (a_zero) begin
      spec_res = {sign, 31'd0};
      spec_exc = 2'b11;
    end else begin
      is_special = 1'b0;
    end
  end

  // Divider output is flushed on its own sign: underflow to zero, overflow to inf.
  always_comb begin
    q_fl  = DIV_Q;
    q_exc = 2'b00;
    if (DIV_Q[30:23] == 8'd0) begin
      q_fl = {DIV_Q[31], 31'd0};
    end else if (DIV_Q[30:23] == 8'hFF) begin
      q_fl  = {DIV_Q[31], 8'hFF, 23'd0};
      q_exc = 2'b11;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    div_a_d = div_a_q;
    div_b_d = div_b_q;
    abyb_d  = abyb_q;
    exc_d   = exc_q;
    case (state_q)
      IDLE: begin
        if (IN_VALID) begin
          if (is_special) begin
            abyb_d  = spec_res;
            exc_d   = spec_exc;
            state_d = HOLD;
          end else begin
            div_a_d = a_fl;
            div_b_d = b_fl;
            cnt_d   = CNT_INIT;
            state_d = BUSY;
          end
        end
      end
      BUSY: begin
        if (cnt_q == 8'd0) begin
          abyb_d  = q_fl;
          exc_d   = q_exc;
          state_d = HOLD;
        end else begin
          cnt_d = cnt_q - 8'd1;
        end
      end
      HOLD: begin
        if (OUT_READY) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge CLOCK) begin
    if (!RESET) begin
      state_q <= IDLE;
      cnt_q   <= 8'd0;
      div_a_q <= 32'd0;
      div_b_q <= 32'd0;
      abyb_q  <= 32'd0;
      exc_q   <= 2'b00;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      div_a_q <= div_a_d;
      div_b_q <= div_b_d;
      abyb_q  <= abyb_d;
      exc_q   <= exc_d;
    end
  end

  assign IN_READY  = (state_q == IDLE);
  assign OUT_VALID = (state_q == HOLD);
  assign DONE      = OUT_VALID & OUT_READY;
  assign DIV_A     = div_a_q;
  assign DIV_B     = div_b_q;
  assign AbyB      = abyb_q;
  assign EXCEPTION = exc_q;

endmodule

// File: tb/tb_fpdiv_sequencer.sv
// Randomized and directed bench for fpdiv_sequencer against a behavioural divide-classification model.
// A second instance with SETTLE_CYCLES=1 covers the minimum settle time and back-to-back spacing.
module tb_fpdiv_sequencer;

  localparam int SETTLE = 25;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  logic        rst_n;
  logic        in_vld, in_rdy, out_vld, out_rdy, done;
  logic [31:0] in_a, in_b, div_a, div_b, div_q, abyb;
  logic [1:0]  exc;

  logic        in_vld1, in_rdy1, out_vld1, out_rdy1, done1;
  logic [31:0] in_a1, in_b1, div_a1, div_b1, div_q1, abyb1;
  logic [1:0]  exc1;

  fpdiv_sequencer #(.SETTLE_CYCLES(SETTLE)) dut (
    .CLOCK(clk), .RESET(rst_n), .IN_VALID(in_vld), .IN_READY(in_rdy),
    .InputA(in_a), .InputB(in_b), .DIV_A(div_a), .DIV_B(div_b), .DIV_Q(div_q),
    .OUT_VALID(out_vld), .OUT_READY(out_rdy), .AbyB(abyb), .DONE(done), .EXCEPTION(exc)
  );

  fpdiv_sequencer #(.SETTLE_CYCLES(1)) dut1 (
    .CLOCK(clk), .RESET(rst_n), .IN_VALID(in_vld1), .IN_READY(in_rdy1),
    .InputA(in_a1), .InputB(in_b1), .DIV_A(div_a1), .DIV_B(div_b1), .DIV_Q(div_q1),
    .OUT_VALID(out_vld1), .OUT_READY(out_rdy1), .AbyB(abyb1), .DONE(done1), .EXCEPTION(exc1)
  );

  int n_checks = 0;
  int n_errors = 0;
  logic [31:0] mdl_div_a = 32'd0;
  logic [31:0] mdl_div_b = 32'd0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask

  function automatic logic [31:0] ftz(input logic [31:0] x);
    return (x[30:23] == 8'd0) ? {x[31], 31'd0} : x;
  endfunction

  // Reference: what a divide of a by b should report, given the divider returns q.
  task automatic ref_div(input logic [31:0] a, input logic [31:0] b, input logic [31:0] q,
                         output logic [31:0] r, output logic [1:0] e, output bit sp);
    logic [31:0] fa, fb;
    logic s;
    bit a_nan, b_nan, a_inf, b_inf, a_zero, b_zero;
    fa = ftz(a);
    fb = ftz(b);
    s = a[31] ^ b[31];
    a_nan  = (fa[30:23] == 8'hFF) && (fa[22:0] != 23'd0);
    b_nan  = (fb[30:23] == 8'hFF) && (fb[22:0] != 23'd0);
    a_inf  = (fa[30:23] == 8'hFF) && (fa[22:0] == 23'd0);
    b_inf  = (fb[30:23] == 8'hFF) && (fb[22:0] == 23'd0);
    a_zero = (fa[30:0] == 31'd0);
    b_zero = (fb[30:0] == 31'd0);
    sp = 1'b1;
    if (a_nan || b_nan)           begin r = 32'h7FC00000;        e = 2'b10; end
    else if (a_inf && b_inf)      begin r = 32'h7FC00000;        e = 2'b10; end
    else if (a_zero && b_zero)    begin r = 32'h7FC00000;        e = 2'b10; end
    else if (a_inf)               begin r = {s, 8'hFF, 23'd0};   e = 2'b11; end
    else if (b_inf)               begin r = {s, 31'd0};          e = 2'b11; end
    else if (b_zero)              begin r = {s, 8'hFF, 23'd0};   e = 2'b01; end
    else if (a_zero)              begin r = {s, 31'd0};          e = 2'b11; end
    else begin
      sp = 1'b0;
      if (q[30:23] == 8'd0)       begin r = {q[31], 31'd0};      e = 2'b00; end
      else if (q[30:23] == 8'hFF) begin r = {q[31], 8'hFF, 23'd0}; e = 2'b11; end
      else                        begin r = q;                   e = 2'b00; end
    end
  endtask

  function automatic logic [31:0] rand_op();
    logic s;
    logic [7:0] ex;
    logic [22:0] m;
    s  = 1'($urandom_range(0, 1));
    ex = 8'($urandom_range(1, 254));
    m  = 23'($urandom);
    case ($urandom_range(0, 9))
      0: return {s, 31'd0};
      1: return {s, 8'd0, 23'($urandom_range(1, 23'h7FFFFF))};
      2: return {s, 8'hFF, 23'd0};
      3: return {s, 8'hFF, 23'($urandom_range(1, 23'h7FFFFF))};
      default: return {s, ex, m};
    endcase
  endfunction

  function automatic logic [31:0] rand_q();
    logic [31:0] q;
    q = $urandom;
    case ($urandom_range(0, 7))
      0: q[30:23] = 8'd0;
      1: q[30:23] = 8'hFF;
      default: q[30:23] = 8'($urandom_range(1, 254));
    endcase
    return q;
  endfunction

  // One full transaction on the SETTLE=25 instance; entered and left at a negedge in IDLE.
  task automatic run_txn(input logic [31:0] a, input logic [31:0] b, input logic [31:0] q, input int hold);
    logic [31:0] r;
    logic [1:0] e;
    bit sp;
    int lat;
    ref_div(a, b, q, r, e, sp);
    if (!sp) begin
      mdl_div_a = ftz(a);
      mdl_div_b = ftz(b);
    end
    check("in_rdy_idle", 32'(in_rdy), 32'd1);
    in_vld = 1'b1; in_a = a; in_b = b; div_q = q;
    step();
    in_vld = 1'b0;
    check("ov_after_accept", 32'(out_vld), 32'(sp));
    lat = 0;
    if (!sp) begin
      while (!out_vld && lat < 300) begin
        in_vld = 1'($urandom_range(0, 1));
        in_a = $urandom;
        in_b = $urandom;
        check("div_a_busy", div_a, mdl_div_a);
        step();
        lat++;
      end
      in_vld = 1'b0;
      check("latency", 32'(lat), 32'(SETTLE));
    end
    check("abyb", abyb, r);
    check("exception", 32'(exc), 32'(e));
    check("div_a", div_a, mdl_div_a);
    check("div_b", div_b, mdl_div_b);
    for (int i = 0; i < hold; i++) begin
      in_vld = 1'b1;
      in_a = $urandom;
      in_b = $urandom;
      step();
      check("abyb_hold", abyb, r);
      check("exc_hold", 32'(exc), 32'(e));
      check("ov_hold", 32'(out_vld), 32'd1);
      check("in_rdy_hold", 32'(in_rdy), 32'd0);
    end
    in_vld = 1'b0;
    out_rdy = 1'b1;
    #1;
    check("done_pulse", 32'(done), 32'd1);
    step();
    out_rdy = 1'b0;
    #1;
    check("done_after", 32'(done), 32'd0);
    check("ov_after_done", 32'(out_vld), 32'd0);
    check("in_rdy_after_done", 32'(in_rdy), 32'd1);
    check("div_a_after_done", div_a, mdl_div_a);
    check("div_b_after_done", div_b, mdl_div_b);
  endtask

  initial begin
    bit seen;
    int last_acc;
    int n_acc;
    rst_n = 1'b0;
    in_vld = 1'b1; in_a = 32'h40A00000; in_b = 32'h40000000; div_q = 32'h40200000;
    out_rdy = 1'b1;
    in_vld1 = 1'b0; in_a1 = 32'd0; in_b1 = 32'd0; div_q1 = 32'd0; out_rdy1 = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_out_vld", 32'(out_vld), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    check("rst_abyb", abyb, 32'd0);
    check("rst_exc", 32'(exc), 32'd0);
    check("rst_div_a", div_a, 32'd0);
    check("rst_div_b", div_b, 32'd0);
    check("rst_in_rdy", 32'(in_rdy), 32'd1);
    in_vld = 1'b0;
    out_rdy = 1'b0;
    rst_n = 1'b1;
    step();
    check("post_rst_in_rdy", 32'(in_rdy), 32'd1);
    check("post_rst_out_vld", 32'(out_vld), 32'd0);

    run_txn(32'h40A00000, 32'h40000000, 32'h40200000, 0);
    run_txn(32'h40000000, 32'h00000000, 32'h12345678, 0);
    run_txn(32'h00000000, 32'h00000000, 32'h12345678, 0);
    run_txn(32'h7F800000, 32'h7F800000, 32'h12345678, 0);
    run_txn(32'h40000000, 32'h7F800000, 32'h12345678, 1);
    run_txn(32'hC0000000, 32'h7F800000, 32'h12345678, 0);
    run_txn(32'h00000001, 32'h40000000, 32'h12345678, 0);
    run_txn(32'h3F800000, 32'h40400000, 32'h80123456, 2);
    run_txn(32'h3F800000, 32'h40400000, 32'h7F812345, 0);
    run_txn(32'h40A00000, 32'h40000000, 32'h40200000, 10);

    for (int i = 0; i < 40; i++) begin
      run_txn(rand_op(), rand_op(), rand_q(), int'($urandom_range(0, 3)));
    end

    // Reset in the middle of BUSY discards the transaction.
    in_vld = 1'b1; in_a = 32'h40A00000; in_b = 32'h40000000; div_q = 32'h40200000;
    step();
    in_vld = 1'b0;
    repeat (10) step();
    rst_n = 1'b0;
    step();
    rst_n = 1'b1;
    mdl_div_a = 32'd0;
    mdl_div_b = 32'd0;
    check("busy_rst_in_rdy", 32'(in_rdy), 32'd1);
    check("busy_rst_out_vld", 32'(out_vld), 32'd0);
    check("busy_rst_abyb", abyb, 32'd0);
    check("busy_rst_div_a", div_a, 32'd0);
    seen = 1'b0;
    for (int i = 0; i < 40; i++) begin
      step();
      if (out_vld) seen = 1'b1;
    end
    check("busy_rst_no_result", 32'(seen), 32'd0);

    // SETTLE=1 instance: continuous offers with the consumer always ready.
    in_a1 = 32'h3F800000; in_b1 = 32'h40000000; div_q1 = 32'h3F000000;
    out_rdy1 = 1'b1;
    in_vld1 = 1'b1;
    last_acc = -1;
    n_acc = 0;
    for (int i = 0; i < 30; i++) begin
      if (out_vld1) begin
        check("s1_latency", 32'(cyc - last_acc), 32'd1);
        check("s1_abyb", abyb1, 32'h3F000000);
        check("s1_exc", 32'(exc1), 32'd0);
        check("s1_done", 32'(done1), 32'd1);
      end
      if (in_rdy1) begin
        if (last_acc >= 0) check("s1_spacing", 32'(cyc + 1 - last_acc), 32'd3);
        last_acc = cyc + 1;
        n_acc++;
      end
      step();
    end
    in_vld1 = 1'b0;
    check("s1_accept_count", 32'(n_acc >= 9), 32'd1);
    check("s1_div_a", div_a1, 32'h3F800000);
    repeat (3) step();

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
